// File: rtl/branch_hazard_controller_pkg.sv
// rtl/branch_hazard_controller_pkg.sv - shared encodings and helpers for the branch hazard controller
package branch_hazard_controller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hz_state_t;

  localparam int STALL_CNT_W = 16;
  localparam int REG_ADDR_W  = 5;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic src_match(
    input logic [REG_ADDR_W-1:0] r,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  uses_rs,
    input logic                  uses_rt
  );
    return (r != '0) && (((r == rs) && uses_rs) || ((r == rt) && uses_rt));
  endfunction

endpackage

// File: rtl/hazard_depth_decode.sv
// rtl/hazard_depth_decode.sv - combinational hazard depth decode for the instruction in ID
module hazard_depth_decode
  import branch_hazard_controller_pkg::*;
(
  input  logic                  id_branch,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_ex_dst,
  input  logic                  id_ex_regwrite,
  input  logic                  id_ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_mem_dst,
  input  logic                  ex_mem_memread,
  output logic [1:0]            depth
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = src_match(id_ex_dst,  id_rs, id_rt, id_uses_rs, id_uses_rt);
  assign mem_match = src_match(ex_mem_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);

  // Branches resolve in ID, so they wait for ALU results and for loads two stages out.
  always_comb begin
    depth = 2'd0;
    if (id_branch && id_ex_memread && ex_match)
      depth = 2'd2;
    else if (id_branch && id_ex_regwrite && ex_match)
      depth = 2'd1;
    else if (id_branch && ex_mem_memread && mem_match)
      depth = 2'd1;
    else if (!id_branch && id_ex_memread && ex_match)
      depth = 2'd1;
  end

endmodule

// File: rtl/branch_hazard_controller.sv
// rtl/branch_hazard_controller.sv - stall/flush control for branches resolved in ID
module branch_hazard_controller
  import branch_hazard_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_branch,
  input  logic                   branch_taken,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [REG_ADDR_W-1:0]  id_ex_dst,
  input  logic                   id_ex_regwrite,
  input  logic                   id_ex_memread,
  input  logic [REG_ADDR_W-1:0]  ex_mem_dst,
  input  logic                   ex_mem_memread,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_bubble,
  output logic                   if_id_flush,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  hz_state_t state_q;
  hz_state_t state_d;
  logic [1:0] depth;
  logic       stall;

  hazard_depth_decode u_depth (
    .id_branch      (id_branch),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_ex_dst      (id_ex_dst),
    .id_ex_regwrite (id_ex_regwrite),
    .id_ex_memread  (id_ex_memread),
    .ex_mem_dst     (ex_mem_dst),
    .ex_mem_memread (ex_mem_memread),
    .depth          (depth)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Only a load feeding a branch needs the extra HOLD cycle; depth 1 re-evaluates each cycle.
  always_comb begin
    state_d = IDLE;
    if ((state_q == IDLE) && (depth == 2'd2))
      state_d = HOLD;
  end

  // Reset looks like a stall to the pipeline so nothing advances while it is held.
  always_comb begin
    stall        = reset || (state_q == HOLD) || (depth != 2'd0);
    pc_write     = !stall;
    if_id_write  = !stall;
    id_ex_bubble = stall;
    if_id_flush  = id_branch && branch_taken && !stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_branch_hazard_controller.sv
// tb/tb_branch_hazard_controller.sv - directed self-checking bench for branch_hazard_controller
module tb_branch_hazard_controller;

  logic        clk;
  logic        reset;
  logic        id_branch;
  logic        branch_taken;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  id_ex_dst;
  logic        id_ex_regwrite;
  logic        id_ex_memread;
  logic [4:0]  ex_mem_dst;
  logic        ex_mem_memread;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic [15:0] stall_cycles;

  int checks;
  int failures;

  branch_hazard_controller dut (
    .clk            (clk),
    .reset          (reset),
    .id_branch      (id_branch),
    .branch_taken   (branch_taken),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_ex_dst      (id_ex_dst),
    .id_ex_regwrite (id_ex_regwrite),
    .id_ex_memread  (id_ex_memread),
    .ex_mem_dst     (ex_mem_dst),
    .ex_mem_memread (ex_mem_memread),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_bubble   (id_ex_bubble),
    .if_id_flush    (if_id_flush),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_branch      = 1'b0;
    branch_taken   = 1'b0;
    id_rs          = 5'd0;
    id_rt          = 5'd0;
    id_uses_rs     = 1'b0;
    id_uses_rt     = 1'b0;
    id_ex_dst      = 5'd0;
    id_ex_regwrite = 1'b0;
    id_ex_memread  = 1'b0;
    ex_mem_dst     = 5'd0;
    ex_mem_memread = 1'b0;
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string tag, input logic exp_stall);
    check({tag, ".pc_write"},     32'(pc_write),     32'(!exp_stall));
    check({tag, ".if_id_write"},  32'(if_id_write),  32'(!exp_stall));
    check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(exp_stall));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr();
    reset = 1'b1;
    id_branch    = 1'b1;
    branch_taken = 1'b1;
    #2;
    chk_stall("rst", 1'b1);
    check("rst.flush", 32'(if_id_flush), 32'd0);
    check("rst.cnt", 32'(stall_cycles), 32'd0);
    step();
    step();
    reset = 1'b0;
    clr();
    #1;
    chk_stall("idle_nohaz", 1'b0);
    check("idle_nohaz.cnt", 32'(stall_cycles), 32'd0);

    // Branch on rs=5 with lw to r5 in EX: two stall cycles, then flush.
    step();
    id_branch = 1'b1; branch_taken = 1'b1; id_rs = 5'd5; id_uses_rs = 1'b1;
    id_ex_dst = 5'd5; id_ex_memread = 1'b1; id_ex_regwrite = 1'b1;
    #1;
    chk_stall("lw_br.c1", 1'b1);
    check("lw_br.c1.flush", 32'(if_id_flush), 32'd0);
    step();
    check("lw_br.cnt1", 32'(stall_cycles), 32'd1);
    id_ex_dst = 5'd0; id_ex_memread = 1'b0; id_ex_regwrite = 1'b0;
    #1;
    chk_stall("lw_br.hold", 1'b1);
    check("lw_br.hold.flush", 32'(if_id_flush), 32'd0);
    step();
    check("lw_br.cnt2", 32'(stall_cycles), 32'd2);
    chk_stall("lw_br.after", 1'b0);
    check("lw_br.after.flush", 32'(if_id_flush), 32'd1);
    step();
    check("lw_br.cnt_keep", 32'(stall_cycles), 32'd2);
    clr();
    #1;
    check("lw_br.flush_clear", 32'(if_id_flush), 32'd0);

    // Branch on rt=7 with add to r7 in EX: exactly one stall.
    step();
    id_branch = 1'b1; id_rt = 5'd7; id_uses_rt = 1'b1;
    id_ex_dst = 5'd7; id_ex_regwrite = 1'b1;
    #1;
    chk_stall("alu_br", 1'b1);
    step();
    id_ex_dst = 5'd0; id_ex_regwrite = 1'b0;
    #1;
    chk_stall("alu_br.next", 1'b0);
    check("alu_br.cnt", 32'(stall_cycles), 32'd3);

    // Branch waiting on a load in MEM: one stall.
    step();
    clr();
    id_branch = 1'b1; id_rs = 5'd9; id_uses_rs = 1'b1;
    ex_mem_dst = 5'd9; ex_mem_memread = 1'b1;
    #1;
    chk_stall("mem_lw_br", 1'b1);
    step();
    check("mem_lw_br.cnt", 32'(stall_cycles), 32'd4);
    ex_mem_memread = 1'b0;
    #1;
    chk_stall("mem_lw_br.next", 1'b0);

    // Non-branch load-use: one stall; r0 and unused sources never stall.
    step();
    clr();
    id_rs = 5'd3; id_uses_rs = 1'b1; id_ex_dst = 5'd3; id_ex_memread = 1'b1;
    #1;
    chk_stall("lu", 1'b1);
    step();
    check("lu.cnt", 32'(stall_cycles), 32'd5);
    id_ex_dst = 5'd0;
    #1;
    chk_stall("lu.dst0", 1'b0);
    id_rs = 5'd0;
    #1;
    chk_stall("lu.r0", 1'b0);
    id_branch = 1'b1; id_ex_regwrite = 1'b1; ex_mem_memread = 1'b1;
    #1;
    chk_stall("br.r0", 1'b0);
    id_rs = 5'd3; id_uses_rs = 1'b0; id_ex_dst = 5'd3;
    #1;
    chk_stall("br.unused_rs", 1'b0);
    id_branch = 1'b0; id_ex_memread = 1'b1; ex_mem_memread = 1'b0;
    #1;
    chk_stall("lu.unused_rs", 1'b0);

    // Branch, no hazard, taken: flush one cycle; not taken: no flush.
    step();
    clr();
    id_branch = 1'b1; branch_taken = 1'b1;
    #1;
    check("taken.flush", 32'(if_id_flush), 32'd1);
    chk_stall("taken", 1'b0);
    step();
    clr();
    #1;
    check("taken.flush_one", 32'(if_id_flush), 32'd0);
    id_branch = 1'b1;
    #1;
    check("nottaken.flush", 32'(if_id_flush), 32'd0);
    check("pre_rst.cnt", 32'(stall_cycles), 32'd5);

    // Reset pulse inside HOLD aborts it with no clock edge needed.
    step();
    clr();
    id_branch = 1'b1; id_rs = 5'd5; id_uses_rs = 1'b1;
    id_ex_dst = 5'd5; id_ex_memread = 1'b1;
    step();
    clr();
    #1;
    chk_stall("hold.pre_rst", 1'b1);
    reset = 1'b1;
    #1;
    chk_stall("hold.rst", 1'b1);
    check("hold.rst.cnt", 32'(stall_cycles), 32'd0);
    id_branch = 1'b1; branch_taken = 1'b1;
    #1;
    check("hold.rst.flush", 32'(if_id_flush), 32'd0);
    reset = 1'b0;
    clr();
    #1;
    chk_stall("hold.released", 1'b0);
    step();
    chk_stall("hold.released.edge", 1'b0);
    check("hold.released.cnt", 32'(stall_cycles), 32'd0);

    // Persistent load-use stall saturates the counter.
    id_rs = 5'd4; id_uses_rs = 1'b1; id_ex_dst = 5'd4; id_ex_memread = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    check("sat.reach", 32'(stall_cycles), 32'h0000FFFF);
    for (int i = 0; i < 5; i++) step();
    check("sat.hold", 32'(stall_cycles), 32'h0000FFFF);
    chk_stall("sat", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
